trace_capture_buffer: RTL and testbench

- Consumer end of the traced-signal path: the cycle counter in the hierarchical sub-block produces a per-cycle value; this block samples that value stream into a ring buffer.
- Detects a trigger value, keeps a pre/post-trigger window, then plays the window back to the SystemC harness over a valid/ready read port.
- Instantiated as a sibling of the counter sub-block under the tracing top; marked as a hierarchical block.

---
 rtl/trace_capture_pkg.sv | 11 +
 rtl/trace_ring_mem.sv | 22 ++
 rtl/trace_capture_buffer.sv | 104 ++++++++++
 tb/tb_trace_capture_buffer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/trace_capture_pkg.sv
// Shared types and helpers for the trace capture path.
package trace_capture_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

  // Oldest stored entry: step back `cnt` slots from the write pointer, modulo depth.
  function automatic int unsigned rd_start(int unsigned wp, int unsigned cnt, int unsigned depth);
    return (wp - cnt) & (depth - 1);
  endfunction

endpackage

// File: rtl/trace_ring_mem.sv
// Capture storage: single write port, asynchronous read, no reset.
module trace_ring_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/trace_capture_buffer.sv
// Samples a traced value stream into a ring, holds a pre/post-trigger window
// and plays it back oldest-first over a valid/ready port.
module trace_capture_buffer
  import trace_capture_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic [DATA_W-1:0] trig_value,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              triggered,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);
  localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);

  state_t state, state_nxt;

  logic [AW-1:0]     wr_ptr, rd_ptr, post_cnt, wr_ptr_nxt;
  logic [AW:0]       count, remaining, count_nxt;
  logic [DATA_W-1:0] trig_q;
  logic              capture, hit, xfer;

  assign capture    = sample_valid && (state == ARMED || state == POST);
  assign hit        = capture && (state == ARMED) && (sample_data == trig_q);
  assign xfer       = rd_valid && rd_ready;
  assign wr_ptr_nxt = wr_ptr + 1'b1;
  // Saturate at DEPTH: once full, new writes silently replace the oldest entry.
  assign count_nxt  = (count == FULL) ? count : count + 1'b1;

  assign rd_valid = (state == DONE);
  assign rd_last  = rd_valid && (remaining == (AW+1)'(1));
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arm) state_nxt = ARMED;
      ARMED:   if (hit) state_nxt = (POST_TRIG == 0) ? DONE : POST;
      POST:    if (capture && post_cnt == AW'(1)) state_nxt = DONE;
      DONE:    if (xfer && rd_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      post_cnt  <= '0;
      count     <= '0;
      remaining <= '0;
      trig_q    <= '0;
      triggered <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && arm) begin
        trig_q    <= trig_value;
        count     <= '0;
        triggered <= 1'b0;
      end
      if (capture) begin
        wr_ptr <= wr_ptr_nxt;
        count  <= count_nxt;
      end
      if (hit) begin
        triggered <= 1'b1;
        post_cnt  <= POST_INIT;
      end else if (capture && state == POST) begin
        post_cnt <= post_cnt - 1'b1;
      end
      // DONE is only entered on a capture, so the window is sized from the post-write pointers.
      if (state != DONE && state_nxt == DONE) begin
        rd_ptr    <= AW'(rd_start(32'(wr_ptr_nxt), 32'(count_nxt), DEPTH));
        remaining <= count_nxt;
      end else if (xfer) begin
        rd_ptr    <= rd_ptr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

  trace_ring_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (capture),
    .waddr (wr_ptr),
    .wdata (sample_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Two instances (POST_TRIG=4 and 0) on shared stimulus, checked every cycle against a queue model.
module tb_trace_capture_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset, arm, sample_valid, rd_ready;
  logic [DW-1:0] trig_value, sample_data;
  logic [1:0]    rd_valid, rd_last, triggered, busy;
  logic [DW-1:0] rd_data [2];

  always #5 clk = ~clk;

  trace_capture_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .POST_TRIG(4)) dut (
    .clk(clk), .reset(reset), .arm(arm), .trig_value(trig_value),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .rd_valid(rd_valid[0]), .rd_ready(rd_ready), .rd_data(rd_data[0]),
    .rd_last(rd_last[0]), .triggered(triggered[0]), .busy(busy[0]));

  trace_capture_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .POST_TRIG(0)) dut0 (
    .clk(clk), .reset(reset), .arm(arm), .trig_value(trig_value),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .rd_valid(rd_valid[1]), .rd_ready(rd_ready), .rd_data(rd_data[1]),
    .rd_last(rd_last[1]), .triggered(triggered[1]), .busy(busy[1]));

  int nvec = 0;
  int nerr = 0;

  // model: phase 0 idle, 1 armed, 2 post, 3 done
  int            phase [2];
  int            post_left [2];
  logic [DW-1:0] trig [2];
  bit            tseen [2];
  logic [DW-1:0] hist [2][$];
  logic [DW-1:0] win  [2][$];

  logic [DW-1:0] got [2][$];
  logic [DW-1:0] lastd [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int pt(input int i);
    return (i == 0) ? 4 : 0;
  endfunction

  task automatic step();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        phase[i] = 0; tseen[i] = 0;
        hist[i].delete(); win[i].delete();
      end else begin
        case (phase[i])
          0: if (arm) begin
            trig[i] = trig_value; hist[i].delete(); tseen[i] = 0; phase[i] = 1;
          end
          1, 2: if (sample_valid) begin
            hist[i].push_back(sample_data);
            if (hist[i].size() > DEPTH) void'(hist[i].pop_front());
            if (phase[i] == 1) begin
              if (sample_data == trig[i]) begin
                tseen[i] = 1; post_left[i] = pt(i); phase[i] = 2;
              end
            end else begin
              post_left[i]--;
            end
            if (phase[i] == 2 && post_left[i] == 0) begin
              win[i] = hist[i]; phase[i] = 3;
            end
          end
          default: if (rd_ready) begin
            void'(win[i].pop_front());
            if (win[i].size() == 0) phase[i] = 0;
          end
        endcase
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rd_valid%0d", i), rd_valid[i], phase[i] == 3);
      chk($sformatf("busy%0d", i), busy[i], phase[i] != 0);
      chk($sformatf("triggered%0d", i), triggered[i], tseen[i]);
      if (phase[i] == 3 && win[i].size() > 0) begin
        chk($sformatf("rd_data%0d", i), rd_data[i], win[i][0]);
        chk($sformatf("rd_last%0d", i), rd_last[i], win[i].size() == 1);
      end
    end
  endtask

  task automatic cyc();
    for (int i = 0; i < 2; i++)
      if (rd_valid[i] && rd_ready && !reset) begin
        got[i].push_back(rd_data[i]);
        if (rd_last[i]) lastd[i] = rd_data[i];
      end
    step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // vmode/rmode: 0 always, 1 pattern (toggle / every third), 2 random
  task automatic run_ep(input logic [DW-1:0] tv, input int vmode, input int rmode,
                        input bit noise, input int rst_after);
    int unsigned cnt = 0;
    int c = 0;
    bit fin = 0;
    if (phase[0] != 0 || phase[1] != 0) begin
      reset = 1; cyc(); reset = 0;
    end
    for (int i = 0; i < 2; i++) begin got[i].delete(); lastd[i] = '1; end
    arm = 1; trig_value = tv; sample_valid = 1; sample_data = 32'hDEAD_BEEF; rd_ready = 0;
    cyc();
    arm = 0;
    while (!fin && c < 1000) begin
      if (rst_after > 0 && got[0].size() >= rst_after) begin
        reset = 1; sample_valid = 0; cyc(); reset = 0;
        chk("rst_rd_valid", rd_valid[0], 1'b0);
        chk("rst_busy", busy[0], 1'b0);
        chk("rst_triggered", triggered[0], 1'b0);
        fin = 1;
      end else begin
        sample_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
        sample_data  = DW'(cnt);
        rd_ready     = (rmode == 0) ? 1'b1 : (rmode == 1) ? (c % 3 == 2) : 1'($urandom_range(0, 1));
        arm          = noise && ($urandom_range(0, 3) == 0);
        cyc();
        arm = 0;
        if (sample_valid) cnt++;
        c++;
        if (phase[0] == 0) fin = 1;
      end
    end
    if (!fin) chk("timeout", 1, 0);
  endtask

  initial begin
    reset = 1; arm = 0; sample_valid = 0; rd_ready = 0;
    trig_value = '0; sample_data = '0;
    for (int i = 0; i < 2; i++) begin phase[i] = 0; tseen[i] = 0; end
    cyc(); cyc();
    chk("reset_busy", busy, 2'b00);
    chk("reset_valid", rd_valid, 2'b00);
    chk("reset_last", rd_last, 2'b00);
    reset = 0;

    run_ep(5, 0, 0, 0, 0);
    chk("basic_n", got[0].size(), 10);
    chk("basic_first", got[0].size() > 0 ? got[0][0] : '1, 0);
    chk("basic_last", lastd[0], 9);
    chk("basic_pt0_n", got[1].size(), 6);

    run_ep(40, 0, 0, 0, 0);
    chk("ovw_n", got[0].size(), 16);
    chk("ovw_first", got[0].size() > 0 ? got[0][0] : '1, 29);
    chk("ovw_last", lastd[0], 44);

    run_ep(3, 1, 1, 0, 0);
    chk("gap_n", got[0].size(), 8);
    for (int k = 0; k < got[0].size(); k++) chk("gap_seq", got[0][k], DW'(k));

    run_ep(2, 0, 2, 0, 0);
    chk("pt0_n", got[1].size(), 3);
    chk("pt0_last", lastd[1], 2);

    run_ep(6, 0, 2, 1, 0);
    chk("ign_arm_n", got[0].size(), 11);
    chk("ign_arm_last", lastd[0], 10);

    run_ep(10, 0, 1, 0, 3);
    run_ep(7, 2, 2, 0, 0);
    chk("post_rst_n", got[0].size(), 12);

    for (int e = 0; e < 8; e++)
      run_ep(DW'($urandom_range(0, 50)), $urandom_range(0, 2), $urandom_range(0, 2),
             1'($urandom_range(0, 1)), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
